pipeline_stage_buffer: RTL and testbench
========================================

# pipeline_stage_buffer

Parametrised inter-stage buffer for the five-stage core (IF→ID→EX→IO→WB), replacing the hand-written per-stage valid/data registers. It carries one packed stage bus (e.g. `IDToEXDecodeBusData` without its `valid` bit) between two stages using a valid/allowin handshake. DEPTH 1 is the classic pipeline register; DEPTH ≥ 2 is a circular skid/FIFO buffer that breaks the combinational allowin chain. A flush input discards all held entries on branch or exception redirect.

## Interface
- `DATA_WIDTH`, 32: payload width in bits, normally `$bits(<StageBus>) - 1`.
- `DEPTH`, 2: number of entries, legal range 1..8; elaboration error outside it.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `upstream_valid`  in  1  producer stage offers `upstream_data` this cycle.
- `upstream_data`  in  DATA_WIDTH  payload from the producer.
- `upstream_allowin`  out  1  buffer accepts a push this cycle.
- `downstream_valid`  out  1  head entry is present.
- `downstream_data`  out  DATA_WIDTH  head entry payload; all-zero when empty.
- `downstream_allowin`  in  1  consumer takes the head entry this cycle.
- `flush`  in  1  discard all entries; dominates push and pop.
- `occupancy`  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Push = `upstream_valid && upstream_allowin`. Pop = `downstream_valid && downstream_allowin`.
- DEPTH == 1: `upstream_allowin = !downstream_valid || downstream_allowin`. Push and pop in the same cycle are accepted (pass-through refill), and occupancy stays 1.
- DEPTH ≥ 2: `upstream_allowin = (occupancy != DEPTH)`. It depends on registered state only, with no combinational path from `downstream_allowin`. When full, a push is refused even if a pop happens in the same cycle.
- Storage: DEPTH entries, write pointer and read pointer. Each pointer increments by 1 on its event and wraps from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
- Occupancy update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `downstream_valid = (occupancy != 0)`. `downstream_data` = entry at the read pointer when valid, else 0.
- `flush`: at the next edge occupancy, write pointer and read pointer become 0. A push or pop in the flush cycle has no effect. `upstream_allowin` is not forced low during flush.
- A pop when empty, or a push when `upstream_allowin` = 0, is impossible by definition and leaves state unchanged.

## Timing
- Reset values: occupancy 0, pointers 0, storage 0. Resulting outputs: `downstream_valid` 0, `downstream_data` 0, `upstream_allowin` 1, `occupancy` 0.
- Reset is asynchronous on assertion and synchronous to `clock` on deassertion. Reset mid-stream drops all entries immediately.
- Latency: a data push at edge N appears on `downstream_*` after edge N when the buffer was empty. The minimum is 1 cycle and there is no same-cycle bypass.
- Throughput is 1 entry per cycle in steady state for all DEPTH. DEPTH ≥ 2 sustains 1 per cycle because a pop frees a slot that becomes visible at the next edge.
- Entries leave strictly in FIFO order.

## Structure
- Add package `pipeline_buffer_params` to the shared CPU params header, holding:
  - `MAX_BUFFER_DEPTH = 8`;
  - function `occupancy_width(depth)` returning `$clog2(depth+1)`.
- Stage bus structs stay in their stage packages. Instantiating stages pack and unpack the `valid` bit around the buffer.
- One sub-module, `pipeline_buffer_pointer`: a wrap-at-DEPTH counter with increment and clear inputs, used for both pointers.

## Test plan
- DEPTH=1: push 0xA5A5A5A5 while `downstream_allowin`=1 every cycle, then stream 0x1, 0x2, 0x3 back-to-back. Required: one per cycle, in order, with `upstream_allowin` held 1.
- DEPTH=2, `downstream_allowin`=0: push 0x11, then 0x22. Required: occupancy 2 and `upstream_allowin`=0. A third push of 0x33 is refused. Release the consumer; required output 0x11, then 0x22.
- DEPTH=3 (non-power-of-2): 10 push/pop pairs with data 0..9 and a 1-cycle consumer lag. Required: output 0..9 in order and pointers wrap 2→0 correctly.
- DEPTH=4, buffer holding 3 entries: assert `flush` in the same cycle as a push of 0x44 and a pop. Required next cycle: occupancy 0, `downstream_valid` 0, `downstream_data` 0, and 0x44 never emitted.
- DEPTH=2, one entry held: drop `reset_n` between edges. Required immediately: `downstream_valid` 0 and `upstream_allowin` 1. After release, a push of 0x55 emits 0x55 only.
- DEPTH=2 full, with push and pop in the same cycle. Required: only the pop takes effect, and occupancy goes 2→1.

Source files
------------

// File: rtl/pipeline_buffer_params.sv
// Shared parameters and helpers for the inter-stage pipeline buffers.
package pipeline_buffer_params;

    localparam int unsigned MAX_BUFFER_DEPTH = 8;

    function automatic int unsigned occupancy_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_buffer_pointer.sv
// Wrap-at-DEPTH counter used for both the read and write pointers of a stage buffer.
module pipeline_buffer_pointer #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 increment,
    input  logic                 clear,
    output logic [PTR_WIDTH-1:0] value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (increment) begin
            // Explicit compare keeps non-power-of-2 depths wrapping correctly.
            value <= (value == PTR_WIDTH'(DEPTH - 1)) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Valid/allowin buffer between two pipeline stages: a plain register at DEPTH 1,
// a circular skid FIFO at DEPTH >= 2 that cuts the combinational allowin chain.
module pipeline_stage_buffer
    import pipeline_buffer_params::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned OCC_WIDTH = occupancy_width(DEPTH),
    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  upstream_valid,
    input  logic [DATA_WIDTH-1:0] upstream_data,
    output logic                  upstream_allowin,
    output logic                  downstream_valid,
    output logic [DATA_WIDTH-1:0] downstream_data,
    input  logic                  downstream_allowin,
    input  logic                  flush,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    if (DEPTH == 0 || DEPTH > MAX_BUFFER_DEPTH) begin : g_depth_check
        $error("pipeline_stage_buffer: DEPTH must be in 1..%0d", MAX_BUFFER_DEPTH);
    end

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  push, pop;

    always_comb begin
        downstream_valid = (occ_q != '0);
        if (DEPTH == 1) begin
            // Single register may refill in the same cycle its entry leaves.
            upstream_allowin = !downstream_valid || downstream_allowin;
        end else begin
            upstream_allowin = (occ_q != OCC_WIDTH'(DEPTH));
        end
        push = upstream_valid && upstream_allowin;
        pop  = downstream_valid && downstream_allowin;
    end

    always_comb begin
        head = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PTR_WIDTH'(i)) head = storage[i];
        end
        downstream_data = downstream_valid ? head : '0;
        occupancy       = occ_q;
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else begin
            occ_q <= occ_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push && !flush && wr_ptr == PTR_WIDTH'(i)) storage[i] <= upstream_data;
            end
        end
    end

    pipeline_buffer_pointer #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clock     (clock),
        .reset_n   (reset_n),
        .increment (push),
        .clear     (flush),
        .value     (wr_ptr)
    );

    pipeline_buffer_pointer #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clock     (clock),
        .reset_n   (reset_n),
        .increment (pop),
        .clear     (flush),
        .value     (rd_ptr)
    );

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Self-checking bench: directed vector tables plus random traffic against a list-based model
// for DEPTH 1..4 instances running side by side.
module tb_pipeline_stage_buffer;

    localparam int NI = 4;

    logic        clock;
    logic        rst_n;
    logic        uv  [NI];
    logic [31:0] ud  [NI];
    logic        ua  [NI];
    logic        dv  [NI];
    logic [31:0] dd  [NI];
    logic        da  [NI];
    logic        fl  [NI];
    logic [3:0]  occ [NI];

    int checks = 0;
    int errors = 0;

    // Model: each instance holds an ordered list of entries, head at index 0.
    logic [31:0] mdat [NI][8];
    int          mcnt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D = g + 1;
        logic [$clog2(D+1)-1:0] occ_l;
        pipeline_stage_buffer #(
            .DATA_WIDTH (32),
            .DEPTH      (D)
        ) u_dut (
            .clock              (clock),
            .reset_n            (rst_n),
            .upstream_valid     (uv[g]),
            .upstream_data      (ud[g]),
            .upstream_allowin   (ua[g]),
            .downstream_valid   (dv[g]),
            .downstream_data    (dd[g]),
            .downstream_allowin (da[g]),
            .flush              (fl[g]),
            .occupancy          (occ_l)
        );
        assign occ[g] = 4'(occ_l);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          inst;
        logic        uv;
        logic [31:0] ud;
        logic        da;
        logic        fl;
        logic        exp_dv;
        logic [31:0] exp_dd;
        logic        exp_ua;
        int          exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic m_allowin(input int k);
        if (k == 0) return (mcnt[0] == 0) || da[0];
        return mcnt[k] != k + 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NI; k++) mcnt[k] = 0;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NI; k++) begin
            uv[k] = 1'b0; ud[k] = '0; da[k] = 1'b0; fl[k] = 1'b0;
        end
    endtask

    // Compare every instance against the model, advance one edge, update the model.
    task automatic step();
        logic p [NI];
        logic q [NI];
        for (int k = 0; k < NI; k++) begin
            check("model_valid", k, 32'(dv[k]), 32'(mcnt[k] != 0));
            check("model_data", k, dd[k], (mcnt[k] != 0) ? mdat[k][0] : 32'h0);
            check("model_allowin", k, 32'(ua[k]), 32'(m_allowin(k)));
            check("model_occ", k, 32'(occ[k]), 32'(mcnt[k]));
            p[k] = uv[k] && m_allowin(k);
            q[k] = (mcnt[k] != 0) && da[k];
        end
        @(posedge clock);
        for (int k = 0; k < NI; k++) begin
            if (fl[k]) begin
                mcnt[k] = 0;
            end else begin
                if (q[k]) begin
                    for (int j = 0; j < 7; j++) mdat[k][j] = mdat[k][j+1];
                    mcnt[k]--;
                end
                if (p[k]) begin
                    mdat[k][mcnt[k]] = ud[k];
                    mcnt[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic add(input int inst, input logic v, input logic [31:0] d, input logic a,
                       input logic f, input logic edv, input logic [31:0] edd,
                       input logic eua, input int eocc);
        vecs.push_back('{inst, v, d, a, f, edv, edd, eua, eocc});
    endtask

    task automatic run_vecs();
        vec_t t;
        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            idle_inputs();
            uv[t.inst] = t.uv; ud[t.inst] = t.ud; da[t.inst] = t.da; fl[t.inst] = t.fl;
            #1;
            check($sformatf("vec%0d_valid", i), t.inst, 32'(dv[t.inst]), 32'(t.exp_dv));
            check($sformatf("vec%0d_data", i), t.inst, dd[t.inst], t.exp_dd);
            check($sformatf("vec%0d_allowin", i), t.inst, 32'(ua[t.inst]), 32'(t.exp_ua));
            check($sformatf("vec%0d_occ", i), t.inst, 32'(occ[t.inst]), 32'(t.exp_occ));
            step();
        end
        vecs.delete();
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #3 rst_n = 1'b1;
        @(posedge clock);
        #1;

        // DEPTH 1: continuous consumer, back-to-back stream
        add(0, 1, 32'hA5A5A5A5, 1, 0, 0, 32'h0, 1, 0);
        add(0, 1, 32'h1, 1, 0, 1, 32'hA5A5A5A5, 1, 1);
        add(0, 1, 32'h2, 1, 0, 1, 32'h1, 1, 1);
        add(0, 1, 32'h3, 1, 0, 1, 32'h2, 1, 1);
        add(0, 0, 32'h0, 1, 0, 1, 32'h3, 1, 1);
        add(0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        // DEPTH 2: fill with stalled consumer, third push refused, then drain
        add(1, 1, 32'h11, 0, 0, 0, 32'h0, 1, 0);
        add(1, 1, 32'h22, 0, 0, 1, 32'h11, 1, 1);
        add(1, 1, 32'h33, 0, 0, 1, 32'h11, 0, 2);
        add(1, 0, 32'h0, 1, 0, 1, 32'h11, 0, 2);
        add(1, 0, 32'h0, 1, 0, 1, 32'h22, 1, 1);
        add(1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        // DEPTH 3: ten entries with a one-cycle consumer lag, pointers wrap repeatedly
        for (int t = 0; t < 12; t++) begin
            add(2, t < 10, 32'(t), 1, 0, (t >= 1 && t <= 10), (t >= 1 && t <= 10) ? 32'(t - 1) : 32'h0,
                1, (t >= 1 && t <= 10) ? 1 : 0);
        end
        // DEPTH 4: flush with three held entries, colliding with a push and a pop
        add(3, 1, 32'h1, 0, 0, 0, 32'h0, 1, 0);
        add(3, 1, 32'h2, 0, 0, 1, 32'h1, 1, 1);
        add(3, 1, 32'h3, 0, 0, 1, 32'h1, 1, 2);
        add(3, 1, 32'h44, 1, 1, 1, 32'h1, 1, 3);
        add(3, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
        add(3, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
        // DEPTH 2 full: push and pop together, only the pop lands
        add(1, 1, 32'hAA, 0, 0, 0, 32'h0, 1, 0);
        add(1, 1, 32'hBB, 0, 0, 1, 32'hAA, 1, 1);
        add(1, 1, 32'hCC, 1, 0, 1, 32'hAA, 0, 2);
        add(1, 0, 32'h0, 0, 0, 1, 32'hBB, 1, 1);
        add(1, 0, 32'h0, 1, 0, 1, 32'hBB, 1, 1);
        add(1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        run_vecs();

        // Asynchronous reset mid-stream on DEPTH 2
        idle_inputs();
        uv[1] = 1'b1; ud[1] = 32'h77;
        #1;
        step();
        idle_inputs();
        #1;
        check("held_before_reset", 1, 32'(dv[1]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_valid", 1, 32'(dv[1]), 32'h0);
        check("reset_allowin", 1, 32'(ua[1]), 32'h1);
        check("reset_occ", 1, 32'(occ[1]), 32'h0);
        model_clear();
        @(posedge clock);
        #3 rst_n = 1'b1;
        @(posedge clock);
        #1;
        add(1, 1, 32'h55, 0, 0, 0, 32'h0, 1, 0);
        add(1, 0, 32'h0, 1, 0, 1, 32'h55, 1, 1);
        add(1, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
        run_vecs();

        // Random traffic on all depths against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NI; k++) begin
                uv[k] = ($urandom_range(0, 3) != 0);
                ud[k] = $urandom;
                da[k] = ($urandom_range(0, 2) != 0);
                fl[k] = ($urandom_range(0, 19) == 0);
            end
            #1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
